// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load/store unit, bundled for port grouping.
// slave = LSU view, master = environment (core + data memory) view.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_req_o, err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_req_o, err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: aligns stores, builds byte enables, extends loads; >=3 cycles per access.
// Core is stalled while the access is outstanding; memory backpressure via mem_ready_i, bounded by a watchdog.
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk_i,
  input logic         rstn_i,
  riscv_lsu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we, r_tout;
  logic [2:0]    r_size;
  logic [31:0]   r_addr, r_wd, r_rd;

  logic          w_legal, w_accept, w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wd, w_load;
  logic [15:0]   w_half;

  always_comb begin
    w_legal = 1'b0;
    case (bus.core_size_i)
      3'd0, 3'd4: w_legal = 1'b1;
      3'd1, 3'd5: w_legal = ~bus.core_addr_i[0];
      3'd2:       w_legal = (bus.core_addr_i[1:0] == 2'b00);
      default:    w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    w_accept             = 1'b0;
    w_timeout            = 1'b0;
    bus.core_stall_req_o = 1'b0;
    bus.err_o            = 1'b0;
    bus.mem_req_o        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.core_req_i) begin
          if (w_legal) begin
            w_accept             = 1'b1;
            bus.core_stall_req_o = 1'b1;
            w_next               = BUSY;
          end else begin
            bus.err_o = 1'b1;
          end
        end
      end
      BUSY: begin
        bus.mem_req_o        = 1'b1;
        bus.core_stall_req_o = 1'b1;
        if (bus.mem_ready_i) begin
          w_next = DONE;
        end else if (r_cnt == LAST_CNT) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        bus.err_o = r_tout;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Store lane replication and byte enables come from the latched request only.
  always_comb begin
    w_be = 4'b1111;
    w_wd = r_wd;
    case (r_size[1:0])
      2'd0: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wd[7:0]}};
      end
      2'd1: begin
        w_be = 4'b0011 << r_addr[1:0];
        w_wd = {2{r_wd[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = r_wd;
      end
    endcase
  end

  always_comb begin
    w_half = bus.mem_rd_i[15:0];
    case (r_addr[1:0])
      2'd0: w_half = bus.mem_rd_i[15:0];
      2'd1: w_half = bus.mem_rd_i[23:8];
      2'd2: w_half = bus.mem_rd_i[31:16];
      2'd3: w_half = {8'h00, bus.mem_rd_i[31:24]};
      default: w_half = bus.mem_rd_i[15:0];
    endcase
  end

  always_comb begin
    w_load = bus.mem_rd_i;
    case (r_size)
      3'd0:    w_load = {{24{w_half[7]}}, w_half[7:0]};
      3'd4:    w_load = {24'h0, w_half[7:0]};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd5:    w_load = {16'h0, w_half};
      default: w_load = bus.mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_size <= 3'd0;
      r_addr <= 32'h0;
      r_wd   <= 32'h0;
      r_rd   <= 32'h0;
      r_tout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we   <= bus.core_we_i;
        r_size <= bus.core_size_i;
        r_addr <= bus.core_addr_i;
        r_wd   <= bus.core_wd_i;
        r_cnt  <= '0;
      end
      if (r_state == BUSY) begin
        if (bus.mem_ready_i) begin
          r_cnt <= '0;
          if (!r_we) r_rd <= w_load;
        end else if (w_timeout) begin
          r_cnt  <= '0;
          r_rd   <= 32'h0;
          r_tout <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_state == DONE) r_tout <= 1'b0;
    end
  end

  assign bus.mem_we_o   = (r_state == BUSY) & r_we;
  assign bus.mem_be_o   = (r_state == BUSY) ? w_be : 4'b0000;
  assign bus.mem_addr_o = {r_addr[31:2], 2'b00};
  assign bus.mem_wd_o   = w_wd;
  assign bus.core_rd_o  = r_rd;
endmodule

// File: tb/tb_riscv_lsu.sv
// Randomised and directed bench for riscv_lsu against a byte-lane reference model.
module tb_riscv_lsu;
  localparam int TO = 16;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  riscv_lsu_if bus();

  riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access width in bytes, 0 for an unsupported size code.
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] sz, input logic [31:0] addr);
    int n = nbytes(sz);
    return (n != 0) && ((addr % n) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] addr);
    int n = nbytes(sz);
    int mask = ((1 << n) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] out;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) out[8*i +: 8] = wd[8*(i % n) +: 8];
    return out;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] addr,
                                         input logic [31:0] word);
    logic [31:0] s = word >> (8 * (addr % 4));
    logic signed [7:0]  sb = s[7:0];
    logic signed [15:0] sh = s[15:0];
    case (sz)
      3'd0:    return 32'(int'(sb));
      3'd4:    return s & 32'h0000_00FF;
      3'd1:    return 32'(int'(sh));
      3'd5:    return s & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  // One access from IDLE; delay >= TO means memory never answers. Starts and ends at posedge+1.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int delay, input logic [31:0] rdata);
    bit legal = m_legal(sz, addr);
    int stall_cnt = 0;
    int busy_cnt = 0;
    bit tmo = (delay >= TO);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = sz;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("idle_stall", 32'(bus.core_stall_req_o), 32'(legal));
    chk("idle_err", 32'(bus.err_o), 32'(!legal));
    chk("idle_memreq", 32'(bus.mem_req_o), 32'h0);
    if (bus.core_stall_req_o) stall_cnt++;
    @(posedge clk_i); #1;
    bus.core_req_i = 1'b0;
    if (!legal) begin
      @(negedge clk_i);
      chk("ill_after_err", 32'(bus.err_o), 32'h0);
      chk("ill_after_memreq", 32'(bus.mem_req_o), 32'h0);
      chk("ill_after_stall", 32'(bus.core_stall_req_o), 32'h0);
      chk("ill_rd_hold", bus.core_rd_o, exp_rd);
      @(posedge clk_i); #1;
      return;
    end
    for (int k = 0; k < TO; k++) begin
      bus.mem_ready_i = (k == delay);
      bus.mem_rd_i    = (k == delay) ? rdata : $urandom;
      @(negedge clk_i);
      busy_cnt++;
      if (bus.core_stall_req_o) stall_cnt++;
      chk("busy_memreq", 32'(bus.mem_req_o), 32'h1);
      chk("busy_we", 32'(bus.mem_we_o), 32'(we));
      chk("busy_be", 32'(bus.mem_be_o), 32'(m_be(sz, addr)));
      chk("busy_addr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
      if (we) chk("busy_wd", bus.mem_wd_o, m_wd(sz, wd));
      chk("busy_err", 32'(bus.err_o), 32'h0);
      @(posedge clk_i); #1;
      if (k == delay) break;
    end
    bus.mem_ready_i = 1'b0;
    bus.mem_rd_i    = $urandom;
    if (tmo)     exp_rd = 32'h0;
    else if (!we) exp_rd = m_load(sz, addr, rdata);
    chk("busy_cycles", 32'(busy_cnt), tmo ? 32'(TO) : 32'(delay + 1));
    @(negedge clk_i);
    chk("done_stall", 32'(bus.core_stall_req_o), 32'h0);
    chk("done_memreq", 32'(bus.mem_req_o), 32'h0);
    chk("done_be", 32'(bus.mem_be_o), 32'h0);
    chk("done_err", 32'(bus.err_o), 32'(tmo));
    chk("done_rd", bus.core_rd_o, exp_rd);
    chk("stall_cycles", 32'(stall_cnt), 32'(busy_cnt + 1));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("post_err", 32'(bus.err_o), 32'h0);
    chk("post_memreq", 32'(bus.mem_req_o), 32'h0);
    chk("post_rd", bus.core_rd_o, exp_rd);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0;
    bus.core_wd_i   = 32'h0;
    bus.mem_rd_i    = 32'h0;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_memreq", 32'(bus.mem_req_o), 32'h0);
    chk("rst_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_be", 32'(bus.mem_be_o), 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wd", bus.mem_wd_o, 32'h0);
    chk("rst_rd", bus.core_rd_o, 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);
    chk("rst_stall", 32'(bus.core_stall_req_o), 32'h0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;

    access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    chk("lb_rd", bus.core_rd_o, 32'hFFFF_FF80);

    // Reset mid-access: start a load, then hold reset low for two edges while BUSY.
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h0000_0040;
    @(posedge clk_i); #1;
    bus.core_req_i = 1'b0;
    @(negedge clk_i);
    chk("rstmid_busy", 32'(bus.mem_req_o), 32'h1);
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rstmid_memreq", 32'(bus.mem_req_o), 32'h0);
      chk("rstmid_rd", bus.core_rd_o, 32'h0);
      chk("rstmid_err", 32'(bus.err_o), 32'h0);
      chk("rstmid_stall", 32'(bus.core_stall_req_o), 32'h0);
    end
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    exp_rd = 32'h0;
    @(negedge clk_i);
    chk("rstmid_idle_memreq", 32'(bus.mem_req_o), 32'h0);
    chk("rstmid_idle_addr", bus.mem_addr_o, 32'h0);
    @(posedge clk_i); #1;

    access(1'b0, 3'd5, 32'h0000_0202, 32'h0, 1, 32'hBEEF_0000);
    chk("lhu_rd", bus.core_rd_o, 32'h0000_BEEF);
    access(1'b0, 3'd1, 32'h0000_0202, 32'h0, 0, 32'hBEEF_0000);
    chk("lh_rd", bus.core_rd_o, 32'hFFFF_BEEF);
    access(1'b1, 3'd0, 32'h0000_0011, 32'h1234_56AB, 3, 32'h0);
    chk("sb_rd_unchanged", bus.core_rd_o, 32'hFFFF_BEEF);
    access(1'b1, 3'd2, 32'h0000_0006, 32'hDEAD_BEEF, 0, 32'h0);
    access(1'b0, 3'd3, 32'h0000_0008, 32'h0, 0, 32'h0);
    access(1'b0, 3'd2, 32'h0000_0020, 32'h0, TO, 32'h0);
    chk("tmo_rd", bus.core_rd_o, 32'h0);
    access(1'b0, 3'd2, 32'h0000_0024, 32'h0, 2, 32'hCAFE_F00D);
    chk("after_tmo_rd", bus.core_rd_o, 32'hCAFE_F00D);

    for (int t = 0; t < 60; t++) begin
      logic [2:0]  sz   = 3'($urandom_range(0, 7));
      logic [31:0] addr = $urandom;
      int          dly  = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
      access(1'($urandom_range(0, 1)), sz, addr, $urandom, dly, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
